// File: rtl/cpu_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, bus widths and the
// memory access payload.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBG  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic              we;
  } mem_acc_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (default owner)
// and a debug/loader port with a bounded-wait starvation guard.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_memread_i,
  input  logic              cpu_memwrite_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned WORD_W = ADDR_W - 2;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic     cpu_busy;
  logic     in_range;
  logic     wait_max;
  logic     grant;
  mem_acc_t cpu_acc, dbg_acc, mem_acc;

  assign cpu_busy = cpu_memread_i | cpu_memwrite_i;
  assign in_range = dbg_addr_i[ADDR_W-1:2] < WORD_W'(DEPTH);
  assign wait_max = (wait_q == CNT_W'(MAX_WAIT - 1));
  assign grant    = (state_q == IDLE) & dbg_req_i & (~cpu_busy | wait_max);

  assign cpu_acc = '{addr: cpu_addr_i, wdata: cpu_wdata_i,
                     re: cpu_memread_i, we: cpu_memwrite_i};
  assign dbg_acc = '{addr: dbg_addr_i, wdata: dbg_wdata_i,
                     re: ~dbg_we_i & in_range, we: dbg_we_i & in_range};

  // Next state, starvation counter and the memory-port mux
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_acc     = cpu_acc;
    cpu_rdata_o = mem_rdata_i;
    cpu_stall_o = 1'b0;

    unique case (state_q)
      IDLE: if (grant) state_d = DBG;
      DBG: begin
        mem_acc     = dbg_acc;
        cpu_rdata_o = '0;
        cpu_stall_o = cpu_busy;
        state_d     = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter only advances while a blocked request waits in IDLE
    if (!dbg_req_i || grant) begin
      wait_d = '0;
    end else if ((state_q == IDLE) && cpu_busy && !wait_max) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  assign mem_addr_o  = mem_acc.addr;
  assign mem_wdata_o = mem_acc.wdata;
  assign mem_re_o    = mem_acc.re;
  assign mem_we_o    = mem_acc.we;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ack_q   <= (state_q == DBG);
      if (state_q == DBG) begin
        rdata_q <= (in_range && !dbg_we_i) ? mem_rdata_i : '0;
      end
    end
  end

  assign dbg_ack_o   = ack_q;
  assign dbg_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word data memory.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_memread_i, cpu_memwrite_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ack_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_re_o, mem_we_o;

  logic [31:0] mem [0:31];
  logic        load;
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_arbiter #(.DEPTH(32), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_memread_i(cpu_memread_i), .cpu_memwrite_i(cpu_memwrite_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_addr_o[6:2]];

  always @(posedge clk_i) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(100 + i);
      mem[0] <= 32'd5;
      mem[2] <= 32'd10;
      mem[4] <= 32'd29;
    end else if (mem_we_o) begin
      mem[mem_addr_o[6:2]] <= mem_wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [5:0] ack_pat;
    logic [5:0] re_pat;
    ack_pat = 6'b100100;
    re_pat  = 6'b010010;

    rst_i = 1'b0; load = 1'b1;
    cpu_memread_i = 0; cpu_memwrite_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    #2;
    chk("rst_ack", 32'(dbg_ack_o), 32'd0);
    chk("rst_rdata", dbg_rdata_o, 32'd0);
    chk("rst_stall", 32'(cpu_stall_o), 32'd0);
    nxt(); nxt();
    rst_i = 1'b1; load = 1'b0;

    // CPU-only load
    nxt();
    cpu_memread_i = 1; cpu_addr_i = 32'h08;
    #1;
    chk("cpu_rdata", cpu_rdata_o, 32'd10);
    chk("cpu_mem_re", 32'(mem_re_o), 32'd1);
    chk("cpu_stall", 32'(cpu_stall_o), 32'd0);
    chk("cpu_ack", 32'(dbg_ack_o), 32'd0);

    // Debug read with idle CPU
    nxt();
    cpu_memread_i = 0;
    dbg_req_i = 1; dbg_addr_i = 32'h10; dbg_we_i = 0;
    #1;
    chk("rd_idle_ack", 32'(dbg_ack_o), 32'd0);
    chk("rd_idle_re", 32'(mem_re_o), 32'd0);
    nxt();
    chk("rd_dbg_addr", mem_addr_o, 32'h10);
    chk("rd_dbg_re", 32'(mem_re_o), 32'd1);
    chk("rd_dbg_we", 32'(mem_we_o), 32'd0);
    chk("rd_dbg_cpurd", cpu_rdata_o, 32'd0);
    chk("rd_dbg_stall", 32'(cpu_stall_o), 32'd0);
    nxt();
    chk("rd_ack", 32'(dbg_ack_o), 32'd1);
    chk("rd_data", dbg_rdata_o, 32'd29);
    dbg_req_i = 0;
    nxt();
    chk("rd_ack_drop", 32'(dbg_ack_o), 32'd0);
    chk("rd_data_hold", dbg_rdata_o, 32'd29);

    // Out-of-range debug read
    dbg_req_i = 1; dbg_addr_i = 32'h80;
    nxt();
    chk("oor_re", 32'(mem_re_o), 32'd0);
    chk("oor_we", 32'(mem_we_o), 32'd0);
    nxt();
    chk("oor_ack", 32'(dbg_ack_o), 32'd1);
    chk("oor_data", dbg_rdata_o, 32'd0);
    dbg_req_i = 0;
    nxt();

    // Debug write starved by continuous CPU loads
    cpu_memread_i = 1; cpu_addr_i = 32'h08;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h14; dbg_wdata_i = 32'hAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wait%0d_stall", i), 32'(cpu_stall_o), 32'd0);
      chk($sformatf("wait%0d_addr", i), mem_addr_o, 32'h08);
      nxt();
    end
    chk("frc_stall", 32'(cpu_stall_o), 32'd1);
    chk("frc_we", 32'(mem_we_o), 32'd1);
    chk("frc_addr", mem_addr_o, 32'h14);
    chk("frc_wdata", mem_wdata_o, 32'hAA);
    chk("frc_cpurd", cpu_rdata_o, 32'd0);
    nxt();
    chk("frc_ack", 32'(dbg_ack_o), 32'd1);
    chk("frc_ack_stall", 32'(cpu_stall_o), 32'd0);
    chk("frc_held_rd", cpu_rdata_o, 32'd10);
    chk("frc_held_re", 32'(mem_re_o), 32'd1);
    chk("frc_wr_rdata", dbg_rdata_o, 32'd0);
    dbg_req_i = 0; dbg_we_i = 0;
    nxt();
    cpu_addr_i = 32'h14;
    #1;
    chk("frc_mem5", cpu_rdata_o, 32'hAA);
    cpu_memread_i = 0;

    // Request held high through ack: two separate transactions
    nxt();
    dbg_req_i = 1; dbg_addr_i = 32'h10; dbg_we_i = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("b2b%0d_ack", i), 32'(dbg_ack_o), 32'(ack_pat[i]));
      chk($sformatf("b2b%0d_re", i), 32'(mem_re_o), 32'(re_pat[i]));
      nxt();
    end
    dbg_req_i = 0;
    chk("b2b_data", dbg_rdata_o, 32'd29);

    // Async reset in the middle of a debug write
    nxt();
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h00; dbg_wdata_i = 32'h77;
    nxt();
    chk("rdbg_we", 32'(mem_we_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rdbg_we_rst", 32'(mem_we_o), 32'd0);
    chk("rdbg_ack_rst", 32'(dbg_ack_o), 32'd0);
    chk("rdbg_rdata_rst", dbg_rdata_o, 32'd0);
    dbg_req_i = 0; dbg_we_i = 0;
    nxt();
    chk("rdbg_ack_hold", 32'(dbg_ack_o), 32'd0);
    rst_i = 1'b1;
    cpu_memread_i = 1; cpu_addr_i = 32'h00;
    #1;
    chk("rdbg_mem0", cpu_rdata_o, 32'd5);
    chk("rdbg_idle_re", 32'(mem_re_o), 32'd1);
    nxt();
    chk("rdbg_no_ack", 32'(dbg_ack_o), 32'd0);
    cpu_memread_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbiter that shares the single-port Data_Memory between the pipeline MEM stage and a debug/loader port. The MEM stage is the default owner. The debug port gets the memory through a req/ack handshake, with a starvation guard that forces a one-cycle pipeline stall. The block sits between Reg_EXMEM/MEM-stage logic and Data_Memory; cpu_stall_o feeds the hazard/stall network, which freezes PC, IF/ID, ID/EX and EX/MEM.

Parameters:
DEPTH, 32, data memory depth in 32-bit words
MAX_WAIT, 4, max consecutive cycles a pending debug request may be blocked by CPU accesses (legal range >= 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
cpu_memread_i  in  1  MEM-stage load
cpu_memwrite_i  in  1  MEM-stage store
cpu_addr_i  in  32  MEM-stage byte address
cpu_wdata_i  in  32  MEM-stage store data
cpu_rdata_o  out  32  load data to MEM/WB
cpu_stall_o  out  1  pipeline freeze request
dbg_req_i  in  1  debug access request (level, held until ack)
dbg_we_i  in  1  debug write enable
dbg_addr_i  in  32  debug byte address
dbg_wdata_i  in  32  debug write data
dbg_rdata_o  out  32  registered debug read data
dbg_ack_o  out  1  one-cycle completion pulse
mem_addr_o  out  32  to Data_Memory
mem_wdata_o  out  32  to Data_Memory
mem_re_o  out  1  to Data_Memory
mem_we_o  out  1  to Data_Memory (written on posedge)
mem_rdata_i  in  32  combinational read data from Data_Memory

Behaviour:
- Reset (rst_i=0, async): state=IDLE, wait_cnt=0, dbg_ack_o=0, dbg_rdata_o=0. Combinational outputs then follow IDLE rules. Reset in DBG or ACK aborts the transaction: no ack, and the memory write is not performed if reset is low at the edge.
- cpu_busy = cpu_memread_i | cpu_memwrite_i.
- IDLE: CPU owns the memory.
  - mem_* = cpu_* passthrough.
  - cpu_rdata_o = mem_rdata_i.
  - cpu_stall_o=0.
- IDLE -> DBG when dbg_req_i & (!cpu_busy | wait_cnt==MAX_WAIT-1).
- wait_cnt: increments in IDLE when dbg_req_i & cpu_busy and no grant occurs. It clears on any transition to DBG and when dbg_req_i=0. It never exceeds MAX_WAIT-1. Width is $clog2(MAX_WAIT+1).
- DBG (exactly one cycle): debug owns the memory.
  - mem_addr_o=dbg_addr_i, mem_wdata_o=dbg_wdata_i.
  - mem_we_o = dbg_we_i & in_range; mem_re_o = !dbg_we_i & in_range.
  - cpu_stall_o = cpu_busy; cpu_rdata_o=0.
  - At the edge, dbg_rdata_o <= (in_range & !dbg_we_i) ? mem_rdata_i : 0.
  - DBG -> ACK.
- ACK (one cycle): dbg_ack_o=1, CPU passthrough as in IDLE, cpu_stall_o=0. ACK -> IDLE. Debug requests are not sampled in ACK. The requester must drop dbg_req_i at the ack edge; a request still high in IDLE is a new request.
- in_range = (dbg_addr_i[31:2] < DEPTH); addr[1:0] is ignored. Out-of-range accesses follow the same 2-cycle latency, perform no memory access, and return 0.
- CPU addresses are not range-checked; that is Data_Memory's responsibility.
- Latency:
  - Grant to ack is 2 cycles.
  - Request to grant is 1 cycle when the CPU is idle.
  - Request to grant is at most MAX_WAIT cycles under continuous CPU traffic.
- dbg_rdata_o holds its value until the next DBG cycle.
- Simultaneous CPU store and forced debug grant: the CPU store is held by the stall, completes in the ACK cycle, and is never dropped.

Decomposition:
- Shared package (cpu_pkg): state encoding (IDLE=2'd0, DBG=2'd1, ACK=2'd2), data/address width constants.
- No sub-module: the FSM, counter and output mux form a single module.

Test Plan:
- CPU only: lw from addr 0x08 with memory[2]=10 -> cpu_rdata_o=10 in the same cycle; cpu_stall_o stays 0; dbg_ack_o stays 0.
- Debug read, CPU idle: dbg_req_i=1, dbg_addr_i=0x10 (memory[4]=29) -> DBG next cycle, dbg_ack_o=1 the cycle after, dbg_rdata_o=29.
- Debug write with CPU busy every cycle, MAX_WAIT=4: write 0x0000_00AA to 0x14 -> grant on the 4th cycle, cpu_stall_o=1 for exactly that cycle, memory[5]=170, and the held CPU access completes in the ACK cycle with correct data.
- Out-of-range: dbg_addr_i=0x80 (word 32) with DEPTH=32 -> mem_we_o/mem_re_o stay 0 in DBG, ack after 2 cycles, dbg_rdata_o=0.
- Back-to-back: dbg_req_i held high through ack -> the next grant occurs no earlier than 1 cycle after ACK, and exactly one ack is seen per request.
- Async reset asserted during DBG with dbg_we_i=1 to 0x00 -> outputs reset immediately, memory[0] stays 5, no ack, state=IDLE after release.
